// File: rtl/lsu_dcache_port_if.sv
// Handshake bundle between the pipeline, the load/store port and the data cache.
// slave is the load/store port's view; master is the view of whatever surrounds it.
interface lsu_dcache_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_type;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        flush;

  logic        dc_valid;
  logic        dc_ready;
  logic        dc_we;
  logic [3:0]  dc_type;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_resp_valid;
  logic [31:0] dc_rdata;
  logic [6:0]  dc_exception;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [6:0]  wb_exception;
  logic [31:0] wb_badv;

  modport slave (
    input  req_valid, req_we, req_type, req_signed, req_addr, req_wdata, req_rd, flush,
    output req_ready,
    output dc_valid, dc_we, dc_type, dc_addr, dc_wdata,
    input  dc_ready, dc_resp_valid, dc_rdata, dc_exception,
    output wb_valid, wb_rd, wb_data, wb_exception, wb_badv,
    input  wb_ready
  );

  modport master (
    output req_valid, req_we, req_type, req_signed, req_addr, req_wdata, req_rd, flush,
    input  req_ready,
    input  dc_valid, dc_we, dc_type, dc_addr, dc_wdata,
    output dc_ready, dc_resp_valid, dc_rdata, dc_exception,
    input  wb_valid, wb_rd, wb_data, wb_exception, wb_badv,
    output wb_ready
  );
endinterface

// File: rtl/lsu_dcache_port.sv
// Single-outstanding load/store port: issues one op to the dcache, aligns/extends the reply
// and holds one writeback record. Define LSU_ALE_PRECHECK_EN to trap misaligned ops locally.
//
// state | meaning
// IDLE  | ready for a new request
// REQ   | dcache request presented, waiting for dc_ready
// WAIT  | request accepted, waiting for the dcache response
// DONE  | writeback record presented, waiting for wb_ready
// DRAIN | op was flushed after acceptance, swallowing its response
module lsu_dcache_port #(
  parameter logic [6:0] EXP_ALE = 7'h09
) (
  input logic             clk,
  input logic             rst,
  lsu_dcache_port_if.slave io
);

  localparam logic [3:0] BYTE = 4'b0001;
  localparam logic [3:0] HALF = 4'b0011;
  localparam logic [3:0] WORD = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_dc_valid;
  logic        r_wb_valid;

  logic        r_we;
  logic [3:0]  r_type;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;

  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic [6:0]  r_wb_exception;
  logic [31:0] r_wb_badv;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_ale;

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0:    w_byte = io.dc_rdata[7:0];
      2'd1:    w_byte = io.dc_rdata[15:8];
      2'd2:    w_byte = io.dc_rdata[23:16];
      default: w_byte = io.dc_rdata[31:24];
    endcase
    w_half = r_addr[1] ? io.dc_rdata[31:16] : io.dc_rdata[15:0];
    case (r_type)
      BYTE:    w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      HALF:    w_load = {{16{r_signed & w_half[15]}}, w_half};
      WORD:    w_load = io.dc_rdata;
      default: w_load = io.dc_rdata;
    endcase
  end

`ifdef LSU_ALE_PRECHECK_EN
  assign w_ale = ((io.req_type == WORD) && (io.req_addr[1:0] != 2'b00)) ||
                 ((io.req_type == HALF) && io.req_addr[0]);
`else
  assign w_ale = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_req_ready    <= 1'b1;
      r_dc_valid     <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_we           <= 1'b0;
      r_type         <= 4'h0;
      r_signed       <= 1'b0;
      r_addr         <= 32'h0;
      r_wdata        <= 32'h0;
      r_rd           <= 5'h0;
      r_wb_rd        <= 5'h0;
      r_wb_data      <= 32'h0;
      r_wb_exception <= 7'h0;
      r_wb_badv      <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io.req_valid && !io.flush) begin
            r_we        <= io.req_we;
            r_type      <= io.req_type;
            r_signed    <= io.req_signed;
            r_addr      <= io.req_addr;
            r_wdata     <= io.req_wdata;
            r_rd        <= io.req_rd;
            r_req_ready <= 1'b0;
            if (w_ale) begin
              // Misaligned op never reaches the dcache; report it directly.
              r_wb_rd        <= io.req_we ? 5'h0 : io.req_rd;
              r_wb_data      <= 32'h0;
              r_wb_exception <= EXP_ALE;
              r_wb_badv      <= io.req_addr;
              r_wb_valid     <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_dc_valid <= 1'b1;
              r_state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (io.flush) begin
            r_dc_valid  <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else if (io.dc_ready) begin
            r_dc_valid <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (io.flush) begin
            if (io.dc_resp_valid) begin
              r_req_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (io.dc_resp_valid) begin
            r_wb_rd        <= r_we ? 5'h0 : r_rd;
            r_wb_exception <= io.dc_exception;
            if (io.dc_exception != 7'h0) begin
              r_wb_data <= 32'h0;
              r_wb_badv <= r_addr;
            end else begin
              r_wb_data <= r_we ? 32'h0 : w_load;
              r_wb_badv <= 32'h0;
            end
            r_wb_valid <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (io.flush || io.wb_ready) begin
            r_wb_valid  <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (io.dc_resp_valid) begin
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_dc_valid  <= 1'b0;
          r_wb_valid  <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // A flush withdraws the dcache request in the same cycle so no handshake can complete.
  assign io.req_ready    = r_req_ready;
  assign io.dc_valid     = r_dc_valid & ~io.flush;
  assign io.dc_we        = r_we;
  assign io.dc_type      = r_type;
  assign io.dc_addr      = r_addr;
  assign io.dc_wdata     = r_wdata;
  assign io.wb_valid     = r_wb_valid;
  assign io.wb_rd        = r_wb_rd;
  assign io.wb_data      = r_wb_data;
  assign io.wb_exception = r_wb_exception;
  assign io.wb_badv      = r_wb_badv;

endmodule

// File: tb/tb_lsu_dcache_port.sv
// Directed bench for lsu_dcache_port: a record-queue model checked every cycle plus literal spot checks.
module tb_lsu_dcache_port;
  localparam logic [6:0] EXP_ALE = 7'h09;
  localparam logic [3:0] BYTE = 4'b0001;
  localparam logic [3:0] HALF = 4'b0011;
  localparam logic [3:0] WORD = 4'b1111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_dcache_port_if bus();

  lsu_dcache_port #(.EXP_ALE(EXP_ALE)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [6:0]  exc;
    logic [31:0] badv;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic dc_allowed = 1'b0;

  logic        c_we;
  logic [3:0]  c_type;
  logic        c_signed;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [4:0]  c_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected record from the access rules: lane = byte offset rounded down to the access width.
  function automatic rec_t model(input logic [31:0] rdata, input logic [6:0] exc);
    rec_t r;
    int width;
    int lane;
    logic [31:0] v;
    logic [31:0] mask;
    width = (c_type == BYTE) ? 8 : (c_type == HALF) ? 16 : 32;
    lane  = (width == 32) ? 0 : (int'(c_addr[1:0]) & ~(width / 8 - 1));
    v     = rdata >> (lane * 8);
    if (width < 32) begin
      mask = (32'h1 << width) - 32'h1;
      v = v & mask;
      if (c_signed && v[width-1]) v = v | ~mask;
    end
    r.exc  = exc;
    r.rd   = c_we ? 5'h0 : c_rd;
    r.badv = (exc != 7'h0) ? c_addr : 32'h0;
    r.data = ((exc != 7'h0) || c_we) ? 32'h0 : v;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("dc_valid", {31'h0, bus.dc_valid}, {31'h0, dc_allowed});
      if (bus.dc_valid) begin
        chk("dc_we", {31'h0, bus.dc_we}, {31'h0, c_we});
        chk("dc_type", {28'h0, bus.dc_type}, {28'h0, c_type});
        chk("dc_addr", bus.dc_addr, c_addr);
        chk("dc_wdata", bus.dc_wdata, c_wdata);
      end
      if (bus.wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("wb_spurious", {31'h0, bus.wb_valid}, 32'h0);
        end else begin
          chk("wb_rd", {27'h0, bus.wb_rd}, {27'h0, exp_q[0].rd});
          chk("wb_data", bus.wb_data, exp_q[0].data);
          chk("wb_exception", {25'h0, bus.wb_exception}, {25'h0, exp_q[0].exc});
          chk("wb_badv", bus.wb_badv, exp_q[0].badv);
          if (bus.wb_ready || bus.flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [3:0] ty, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, output bit sent);
    chk("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_type = ty; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd; bus.req_rd = rd;
    c_we = we; c_type = ty; c_signed = sg; c_addr = a; c_wdata = wd; c_rd = rd;
    step();
    bus.req_valid = 1'b0;
    sent = 1'b1;
`ifdef LSU_ALE_PRECHECK_EN
    if ((ty == WORD && a[1:0] != 2'b00) || (ty == HALF && a[0])) begin
      exp_q.push_back(model(32'h0, EXP_ALE));
      sent = 1'b0;
    end
`endif
    dc_allowed = sent;
  endtask

  task automatic dc_accept(input int stall);
    repeat (stall) step();
    bus.dc_ready = 1'b1;
    step();
    bus.dc_ready = 1'b0;
    dc_allowed = 1'b0;
  endtask

  task automatic dc_respond(input int dly, input logic [31:0] rdata, input logic [6:0] exc, input bit push);
    repeat (dly) step();
    bus.dc_resp_valid = 1'b1; bus.dc_rdata = rdata; bus.dc_exception = exc;
    if (push) exp_q.push_back(model(rdata, exc));
    step();
    bus.dc_resp_valid = 1'b0; bus.dc_rdata = 32'h0; bus.dc_exception = 7'h0;
  endtask

  task automatic wait_wb();
    int k = 0;
    while (!bus.wb_valid && k < 20) begin
      step();
      k++;
    end
    if (!bus.wb_valid) chk("wb_timeout", {31'h0, bus.wb_valid}, 32'h1);
  endtask

  task automatic wb_consume(input string name, input int hold, input logic [4:0] l_rd,
                            input logic [31:0] l_data, input logic [6:0] l_exc, input logic [31:0] l_badv);
    wait_wb();
    chk({name, "_rd"}, {27'h0, bus.wb_rd}, {27'h0, l_rd});
    chk({name, "_data"}, bus.wb_data, l_data);
    chk({name, "_exc"}, {25'h0, bus.wb_exception}, {25'h0, l_exc});
    chk({name, "_badv"}, bus.wb_badv, l_badv);
    repeat (hold) begin
      chk({name, "_req_ready_busy"}, {31'h0, bus.req_ready}, 32'h0);
      step();
    end
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    chk({name, "_wb_valid_after"}, {31'h0, bus.wb_valid}, 32'h0);
    chk({name, "_req_ready_after"}, {31'h0, bus.req_ready}, 32'h1);
    chk({name, "_q_empty"}, exp_q.size(), 32'h0);
  endtask

  task automatic load(input string name, input logic [3:0] ty, input logic sg, input logic [31:0] a,
                      input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] l_data);
    bit sent;
    issue(1'b0, ty, sg, a, 32'h0, rd, sent);
    dc_accept(0);
    dc_respond(1, rdata, 7'h0, 1'b1);
    wb_consume(name, 0, rd, l_data, 7'h0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_req_ready"}, {31'h0, bus.req_ready}, 32'h1);
    chk({name, "_dc_valid"}, {31'h0, bus.dc_valid}, 32'h0);
    chk({name, "_dc_addr"}, bus.dc_addr, 32'h0);
    chk({name, "_dc_wdata"}, bus.dc_wdata, 32'h0);
    chk({name, "_wb_valid"}, {31'h0, bus.wb_valid}, 32'h0);
    chk({name, "_wb_rd"}, {27'h0, bus.wb_rd}, 32'h0);
    chk({name, "_wb_data"}, bus.wb_data, 32'h0);
    chk({name, "_wb_exc"}, {25'h0, bus.wb_exception}, 32'h0);
    chk({name, "_wb_badv"}, bus.wb_badv, 32'h0);
  endtask

  initial begin
    bit sent;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_type = 4'h0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'h0; bus.flush = 1'b0;
    bus.dc_ready = 1'b0; bus.dc_resp_valid = 1'b0; bus.dc_rdata = 32'h0; bus.dc_exception = 7'h0;
    bus.wb_ready = 1'b0;
    c_we = 1'b0; c_type = 4'h0; c_signed = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_rd = 5'h0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    load("ld_word", WORD, 1'b0, 32'h0000_1000, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load("lb_signed", BYTE, 1'b1, 32'h0000_1003, 5'd6, 32'h8012_3456, 32'hFFFF_FF80);
    load("lbu", BYTE, 1'b0, 32'h0000_1003, 5'd6, 32'h8012_3456, 32'h0000_0080);
    load("lh_signed", HALF, 1'b1, 32'h0000_1002, 5'd7, 32'h8012_3456, 32'hFFFF_8012);
    load("lhu_lo", HALF, 1'b0, 32'h0000_1000, 5'd8, 32'h8012_B456, 32'h0000_B456);
    load("lb_lane1", BYTE, 1'b1, 32'h0000_1001, 5'd9, 32'h8012_3456, 32'h0000_0034);

    // Store with dcache stalling; the compare process watches dc_* each stalled cycle.
    issue(1'b1, WORD, 1'b0, 32'h0000_2004, 32'hCAFE_F00D, 5'd3, sent);
    chk("st_dc_wdata", bus.dc_wdata, 32'hCAFE_F00D);
    dc_accept(3);
    dc_respond(0, 32'h1234_5678, 7'h0, 1'b1);
    wb_consume("st_word", 0, 5'd0, 32'h0, 7'h0, 32'h0);

    // Misaligned word load: trapped locally or reported by the dcache.
    issue(1'b0, WORD, 1'b0, 32'h0000_3002, 32'h0, 5'd10, sent);
    if (sent) begin
      dc_accept(0);
      dc_respond(0, 32'h1111_1111, EXP_ALE, 1'b1);
    end
    wb_consume("ale", 0, 5'd10, 32'h0, EXP_ALE, 32'h0000_3002);

    // Flush while waiting: the late response is swallowed.
    issue(1'b0, WORD, 1'b0, 32'h0000_4000, 32'h0, 5'd11, sent);
    dc_accept(0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("drain_req_ready", {31'h0, bus.req_ready}, 32'h0);
    dc_respond(2, 32'h5555_AAAA, 7'h0, 1'b0);
    chk("drain_done_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("drain_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
    load("after_drain", WORD, 1'b0, 32'h0000_4004, 5'd12, 32'h0BAD_F00D, 32'h0BAD_F00D);

    // Flush in REQ beats a simultaneous dc_ready.
    issue(1'b0, WORD, 1'b0, 32'h0000_5000, 32'h0, 5'd13, sent);
    bus.flush = 1'b1; bus.dc_ready = 1'b1; dc_allowed = 1'b0;
    @(negedge clk);
    chk("req_flush_dc_valid", {31'h0, bus.dc_valid}, 32'h0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.dc_ready = 1'b0;
    chk("req_flush_req_ready", {31'h0, bus.req_ready}, 32'h1);
    step();
    chk("req_flush_dc_quiet", {31'h0, bus.dc_valid}, 32'h0);

    // Flush together with the response.
    issue(1'b0, HALF, 1'b1, 32'h0000_6002, 32'h0, 5'd14, sent);
    dc_accept(0);
    bus.flush = 1'b1;
    dc_respond(0, 32'hFFFF_0000, 7'h0, 1'b0);
    bus.flush = 1'b0;
    chk("flush_resp_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("flush_resp_wb_valid", {31'h0, bus.wb_valid}, 32'h0);

    // Backpressure on writeback.
    issue(1'b0, BYTE, 1'b0, 32'h0000_7002, 32'h0, 5'd15, sent);
    dc_accept(1);
    dc_respond(0, 32'h00A5_0000, 7'h0, 1'b1);
    wb_consume("wb_hold", 5, 5'd15, 32'h0000_00A5, 7'h0, 32'h0);

    // Flush in DONE drops the record.
    issue(1'b0, WORD, 1'b0, 32'h0000_8000, 32'h0, 5'd16, sent);
    dc_accept(0);
    dc_respond(0, 32'h0000_0001, 7'h0, 1'b1);
    wait_wb();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("done_flush_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
    chk("done_flush_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("done_flush_q_empty", exp_q.size(), 32'h0);

    // Reset in DONE, then a stale response in IDLE is ignored.
    issue(1'b0, WORD, 1'b0, 32'h0000_9000, 32'h0, 5'd17, sent);
    dc_accept(0);
    dc_respond(0, 32'h7777_7777, 7'h0, 1'b1);
    wait_wb();
    rst = 1'b1;
    step();
    check_reset_outputs("rst_done");
    exp_q.delete();
    dc_allowed = 1'b0;
    rst = 1'b0;
    step();
    dc_respond(0, 32'h9999_9999, 7'h0, 1'b0);
    chk("stale_resp_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
    chk("stale_resp_req_ready", {31'h0, bus.req_ready}, 32'h1);
    load("after_reset", WORD, 1'b0, 32'h0000_A000, 5'd18, 32'h1357_9BDF, 32'h1357_9BDF);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
